tx_framer: RTL

TX_FRAMER -- requirements
Module: tx_framer

---
 rtl/tx_framer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/tx_framer.sv
// Asynchronous serial transmit framer: start bit, 5-8 data bits LSB first,
// optional even/odd parity, 1 or 2 stop bits, with a per-frame baud divider.
`timescale 1ns/1ps
module tx_framer #(
  parameter int unsigned DIV_0 = 10416,
  parameter int unsigned DIV_1 = 5208,
  parameter int unsigned DIV_2 = 2604,
  parameter int unsigned DIV_3 = 868
) (
  input  logic       clk_tx,
  input  logic       rst,
  input  logic [1:0] baud_sel,
  input  logic [4:0] line_control_reg,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       serial_data_tx,
  output logic       active_flag_tx,
  output logic       transmission_done_flag,
  output logic [2:0] state_dbg
);

  // Handshake: a byte moves on a rising edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE, and tx_valid at any other time is ignored.

  localparam int unsigned DIV_A   = (DIV_0 > DIV_1) ? DIV_0 : DIV_1;
  localparam int unsigned DIV_B   = (DIV_2 > DIV_3) ? DIV_2 : DIV_3;
  localparam int unsigned DIV_MAX = (DIV_A > DIV_B) ? DIV_A : DIV_B;
  localparam int          CNT_W   = ($clog2(DIV_MAX) > 14) ? $clog2(DIV_MAX) : 14;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             stop_idx_q, stop_idx_d;
  logic [7:0]       data_q, data_d;
  logic [4:0]       lcr_q, lcr_d;
  logic [1:0]       baud_q, baud_d;
  logic             serial_q, serial_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] bit_div;
  logic             bit_end;
  logic [2:0]       last_idx;
  logic [7:0]       data_mask;
  logic             parity_bit;

  always_comb begin
    bit_div = CNT_W'(DIV_0);
    case (baud_q)
      2'b00: bit_div = CNT_W'(DIV_0);
      2'b01: bit_div = CNT_W'(DIV_1);
      2'b10: bit_div = CNT_W'(DIV_2);
      2'b11: bit_div = CNT_W'(DIV_3);
      default: bit_div = CNT_W'(DIV_0);
    endcase
  end

  assign bit_end    = (cnt_q == bit_div - CNT_W'(1));
  // Word length 5..8 means the last data index is 4..7, i.e. 1 followed by lcr[1:0].
  assign last_idx   = {1'b1, lcr_q[1:0]};
  assign data_mask  = 8'hFF >> (2'd3 - lcr_q[1:0]);
  assign parity_bit = (^(data_q & data_mask)) ^ ~lcr_q[4];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    data_d     = data_q;
    lcr_d      = lcr_q;
    baud_d     = baud_q;
    serial_d   = serial_q;
    done_d     = 1'b0;

    if (state_q == IDLE) begin
      serial_d = 1'b1;
      cnt_d    = '0;
      if (tx_valid) begin
        state_d  = START;
        data_d   = tx_data;
        lcr_d    = line_control_reg;
        baud_d   = baud_sel;
        serial_d = 1'b0;
      end
    end else if (!bit_end) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
      case (state_q)
        START: begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          serial_d  = data_q[0];
        end
        DATA: begin
          if (bit_idx_q == last_idx) begin
            if (lcr_q[3]) begin
              state_d  = PARITY;
              serial_d = parity_bit;
            end else begin
              state_d    = STOP;
              stop_idx_d = 1'b0;
              serial_d   = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            serial_d  = data_q[bit_idx_q + 3'd1];
          end
        end
        PARITY: begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
          serial_d   = 1'b1;
        end
        STOP: begin
          if (stop_idx_q == lcr_q[2]) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
        default: begin
          state_d  = IDLE;
          serial_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_tx or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      data_q     <= 8'd0;
      lcr_q      <= 5'd0;
      baud_q     <= 2'd0;
      serial_q   <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      data_q     <= data_d;
      lcr_q      <= lcr_d;
      baud_q     <= baud_d;
      serial_q   <= serial_d;
      done_q     <= done_d;
    end
  end

  assign tx_ready               = (state_q == IDLE);
  assign active_flag_tx         = (state_q != IDLE);
  assign serial_data_tx         = serial_q;
  assign transmission_done_flag = done_q;
  assign state_dbg              = state_q;

endmodule
